coin_dispense_sequencer: RTL and testbench
==========================================

Name: coin_dispense_sequencer

Overview:
Sequences the ATM coin-tube servos (one Servo_interface per denomination) to pay out a requested amount in cents.
- Greedy coin selection: 25, 10, 5, 1.
- One servo stroke at a time, so only one servo is ever moving (shared supply budget).
- Each stroke is back (push coin) then front (return), handshaking on the per-servo back/front done flags.
- Sits between the transaction FSM (request side) and the four servo instances (servo side).

Parameters:
- TIMEOUT_CYCLES, default 50_000_000: maximum cycles spent waiting on any single servo handshake phase before declaring a fault (0.5 s at 100 MHz).
- AMT_W, default 7: width of the cents amount (0..127).

Ports:
- clk  in  1  system clock
- clr  in  1  synchronous active-high reset
- req_valid  in  1  request strobe
- req_cents  in  AMT_W  amount to dispense
- req_ready  out  1  high in IDLE only; the request is accepted on req_valid && req_ready
- servo_ctrl  out  4  per-servo position command, bit0=penny, bit1=nickel, bit2=dime, bit3=quarter; 1=back/push, 0=front/rest; feeds servoCtrl[0] of each instance
- servo_back_done  in  4  per-servo back-done flag (1=idle/settled)
- servo_front_done  in  4  per-servo front-done flag (1=idle/settled)
- busy  out  1  high from accept until DONE or FAULT
- done  out  1  one-cycle pulse when the amount is fully paid
- fault  out  1  sticky servo-timeout flag; cleared only by clr
- dispensed_cents  out  AMT_W  running total paid for the current or last request

Behaviour:
- Reset (clr=1 at a clk edge), including mid-stroke:
  - state=IDLE, servo_ctrl=0, req_ready=1, busy=0, done=0, fault=0, dispensed_cents=0, remaining=0, timer=0.
  - Dropping servo_ctrl mid-stroke is intentional: it returns every servo to front.
- All outputs are registered.
- FSM states: IDLE, SELECT, PUSH_ACK, PUSH_WAIT, RET_ACK, RET_WAIT, DONE, FAULT.
- IDLE:
  - On accept, latch remaining=req_cents, clear dispensed_cents, set busy=1, go to SELECT.
  - req_valid while not in IDLE is ignored; there is no queueing.
- SELECT:
  - If remaining==0, go to DONE. A request of 0 therefore yields a done pulse 2 cycles after accept, with no servo activity.
  - Otherwise idx = the largest denomination <= remaining; go to PUSH_ACK.
- PUSH_ACK: servo_ctrl[idx]=1; wait for servo_back_done[idx]==0, then go to PUSH_WAIT. The servo acknowledges one or more cycles after the command edge.
- PUSH_WAIT: hold servo_ctrl[idx]=1; wait for servo_back_done[idx]==1, then go to RET_ACK.
- RET_ACK: servo_ctrl[idx]=0; wait for servo_front_done[idx]==0, then go to RET_WAIT.
- RET_WAIT: wait for servo_front_done[idx]==1, then:
  - remaining -= denom[idx]
  - dispensed_cents += denom[idx]
  - go to SELECT.
- Only one servo_ctrl bit may be 1 at any time; all bits are 0 outside PUSH_ACK/PUSH_WAIT.
- Timer:
  - Cleared on entry to each *_ACK and *_WAIT state; increments while in that state.
  - Reaching TIMEOUT_CYCLES goes to FAULT. The comparison is against the timer value, checked before the handshake condition. If the handshake condition and the timeout coincide, the timeout wins.
- DONE: done=1 for exactly one cycle; busy=0; go to IDLE. dispensed_cents holds its value until the next accept.
- FAULT:
  - servo_ctrl=0, busy=0, req_ready=0, fault=1.
  - Stays in FAULT until clr.
  - dispensed_cents shows the coins paid before the fault; the coin in progress is not counted.
- Arithmetic:
  - remaining never underflows, because the selected denomination is always <= remaining.
  - dispensed_cents equals req_cents at DONE.

Optional Feature:
- Macro: COIN_TALLY_EN.
- Defined: adds output tally[31:0], four 8-bit counters in the same bit order as servo_ctrl (quarter at [31:24]).
  - The counter for idx increments on each completed RET_WAIT.
  - Counters saturate at 255.
  - Reset by clr only, not by a new request.
- Not defined: the port and its counters are absent; behaviour is otherwise identical.

Decomposition:
- Package coin_pkg:
  - denomination constants DENOM_Q=25, DENOM_D=10, DENOM_N=5, DENOM_P=1
  - servo index constants
  - state enum typedef
  - AMT_W default
- Sub-module coin_picker: combinational; takes remaining and returns a 2-bit idx and the denomination value. Kept separate so it can be tested exhaustively on 0..127.

Test Plan:
(Bench uses TIMEOUT_CYCLES=1000 and behavioural servo models: done drops 2 cycles after a ctrl edge and rises 50 cycles later.)
- req_cents=41 -> strokes quarter, dime, nickel, penny in that order; one ctrl bit high at a time; done pulse once; dispensed_cents=41.
- req_cents=99 -> 9 strokes (3 quarter, 2 dime, 4 penny); no nickel activity; done; dispensed_cents=99.
- req_cents=0 -> done 2 cycles after accept; servo_ctrl stays 0.
- Quarter model never drops back_done, req_cents=30 -> fault=1 and servo_ctrl=0 exactly 1000 cycles after entering PUSH_ACK; req_ready stays 0 until clr.
- req_valid pulsed during an active request -> ignored; only the first amount is dispensed.
- clr asserted during PUSH_WAIT -> next cycle all outputs are at reset values and req_ready=1; a new req of 5 completes normally.

Source files
------------

// File: rtl/coin_pkg.sv
// Shared constants and types for the coin dispense sequencer.
// Contents:
//   DENOM_*    coin values in cents
//   IDX_*      servo index of each coin tube (also the servo_ctrl bit position)
//   state_t    sequencer state type, with the ST_* state encodings
//   AMT_W_DEF  default width of cents amounts
package coin_pkg;

   localparam int unsigned AMT_W_DEF = 7;

   localparam int unsigned DENOM_Q = 25;
   localparam int unsigned DENOM_D = 10;
   localparam int unsigned DENOM_N = 5;
   localparam int unsigned DENOM_P = 1;

   localparam logic [1:0] IDX_P = 2'd0;
   localparam logic [1:0] IDX_N = 2'd1;
   localparam logic [1:0] IDX_D = 2'd2;
   localparam logic [1:0] IDX_Q = 2'd3;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_SELECT    = 3'd1;
   localparam state_t ST_PUSH_ACK  = 3'd2;
   localparam state_t ST_PUSH_WAIT = 3'd3;
   localparam state_t ST_RET_ACK   = 3'd4;
   localparam state_t ST_RET_WAIT  = 3'd5;
   localparam state_t ST_DONE      = 3'd6;
   localparam state_t ST_FAULT     = 3'd7;

endpackage

// File: rtl/coin_picker.sv
// Greedy coin selection: picks the largest denomination not above the amount.
// Ports:
//   remaining  in   amount still to pay, in cents
//   idx        out  servo index of the chosen coin (IDX_*)
//   denom      out  value of the chosen coin, in cents
// A remaining of 0 returns the penny; the caller never strokes in that case.
module coin_picker
   import coin_pkg::*;
#(
   parameter int unsigned AMT_W = AMT_W_DEF
) (
   input  logic [AMT_W-1:0] remaining,
   output logic [1:0]       idx,
   output logic [AMT_W-1:0] denom
);

   logic [31:0] rem32;
   assign rem32 = 32'(remaining);

   always_comb begin
      idx   = IDX_P;
      denom = AMT_W'(DENOM_P);
      if (rem32 >= DENOM_Q) begin
         idx   = IDX_Q;
         denom = AMT_W'(DENOM_Q);
      end else if (rem32 >= DENOM_D) begin
         idx   = IDX_D;
         denom = AMT_W'(DENOM_D);
      end else if (rem32 >= DENOM_N) begin
         idx   = IDX_N;
         denom = AMT_W'(DENOM_N);
      end
   end

endmodule

// File: rtl/coin_dispense_sequencer.sv
// Pays out a requested amount by stroking one coin-tube servo at a time.
// Each stroke is push (ctrl=1, back_done low then high) followed by return
// (ctrl=0, front_done low then high). A handshake phase lasting
// TIMEOUT_CYCLES cycles parks the block in a sticky fault until clr.
// Ports:
//   clk, clr          clock, synchronous active-high reset
//   req_valid/ready   request handshake, req_cents is the amount
//   servo_ctrl        per-servo command (bit0 penny .. bit3 quarter), 1 = push
//   servo_back_done   per-servo back-settled flags
//   servo_front_done  per-servo front-settled flags
//   busy, done, fault status; done is a one-cycle pulse, fault is sticky
//   dispensed_cents   running total for the current or last request
//   tally             (COIN_TALLY_EN only) saturating 8-bit stroke counters
// Optional: define COIN_TALLY_EN to add the tally port and its counters.
module coin_dispense_sequencer
   import coin_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
   parameter int unsigned AMT_W          = AMT_W_DEF
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             req_valid,
   input  logic [AMT_W-1:0] req_cents,
   output logic             req_ready,
   output logic [3:0]       servo_ctrl,
   input  logic [3:0]       servo_back_done,
   input  logic [3:0]       servo_front_done,
   output logic             busy,
   output logic             done,
   output logic             fault,
`ifdef COIN_TALLY_EN
   output logic [31:0]      tally,
`endif
   output logic [AMT_W-1:0] dispensed_cents
);

   state_t           state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [AMT_W-1:0] remaining_q, remaining_d;
   logic [AMT_W-1:0] dispensed_q, dispensed_d;
   logic [31:0]      timer_q, timer_d;
   logic [3:0]       servo_ctrl_q, servo_ctrl_d;
   logic             req_ready_q, req_ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             fault_q, fault_d;
   logic             stroke_done;
   logic             timed_out;

   logic [1:0]       pick_idx;
   logic [AMT_W-1:0] pick_denom;

   // remaining_q is stable from SELECT through RET_WAIT, so pick_denom
   // always matches the coin currently being stroked.
   coin_picker #(
      .AMT_W (AMT_W)
   ) u_picker (
      .remaining (remaining_q),
      .idx       (pick_idx),
      .denom     (pick_denom)
   );

   // Timer holds the number of full cycles already spent in the phase.
   assign timed_out = (timer_q + 32'd1) >= 32'(TIMEOUT_CYCLES);

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      remaining_d = remaining_q;
      dispensed_d = dispensed_q;
      timer_d     = timer_q;
      stroke_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready_q) begin
               remaining_d = req_cents;
               dispensed_d = '0;
               state_d     = ST_SELECT;
            end
         end
         ST_SELECT: begin
            if (remaining_q == '0) begin
               state_d = ST_DONE;
            end else begin
               idx_d   = pick_idx;
               timer_d = '0;
               state_d = ST_PUSH_ACK;
            end
         end
         ST_PUSH_ACK: begin
            if (timed_out) begin
               state_d = ST_FAULT;
            end else if (!servo_back_done[idx_q]) begin
               timer_d = '0;
               state_d = ST_PUSH_WAIT;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         ST_PUSH_WAIT: begin
            if (timed_out) begin
               state_d = ST_FAULT;
            end else if (servo_back_done[idx_q]) begin
               timer_d = '0;
               state_d = ST_RET_ACK;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         ST_RET_ACK: begin
            if (timed_out) begin
               state_d = ST_FAULT;
            end else if (!servo_front_done[idx_q]) begin
               timer_d = '0;
               state_d = ST_RET_WAIT;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         ST_RET_WAIT: begin
            if (timed_out) begin
               state_d = ST_FAULT;
            end else if (servo_front_done[idx_q]) begin
               remaining_d = remaining_q - pick_denom;
               dispensed_d = dispensed_q + pick_denom;
               stroke_done = 1'b1;
               state_d     = ST_SELECT;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         ST_FAULT: state_d = ST_FAULT;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they are registered yet
   // line up with the state they describe.
   always_comb begin
      servo_ctrl_d = '0;
      if ((state_d == ST_PUSH_ACK) || (state_d == ST_PUSH_WAIT)) begin
         servo_ctrl_d = 4'b0001 << idx_d;
      end
      req_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d == ST_SELECT)    || (state_d == ST_PUSH_ACK) ||
                    (state_d == ST_PUSH_WAIT) || (state_d == ST_RET_ACK)  ||
                    (state_d == ST_RET_WAIT);
      done_d      = (state_d == ST_DONE);
      fault_d     = (state_d == ST_FAULT);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         remaining_q  <= '0;
         dispensed_q  <= '0;
         timer_q      <= '0;
         servo_ctrl_q <= '0;
         req_ready_q  <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         remaining_q  <= remaining_d;
         dispensed_q  <= dispensed_d;
         timer_q      <= timer_d;
         servo_ctrl_q <= servo_ctrl_d;
         req_ready_q  <= req_ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         fault_q      <= fault_d;
      end
   end

`ifdef COIN_TALLY_EN
   logic [3:0][7:0] tally_q;

   // Counts completed strokes per tube; survives new requests, cleared by clr.
   always_ff @(posedge clk) begin
      if (clr) begin
         tally_q <= '0;
      end else if (stroke_done && (tally_q[idx_q] != 8'hFF)) begin
         tally_q[idx_q] <= tally_q[idx_q] + 8'd1;
      end
   end

   assign tally = tally_q;
`endif

   assign servo_ctrl      = servo_ctrl_q;
   assign req_ready       = req_ready_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign fault           = fault_q;
   assign dispensed_cents = dispensed_q;

endmodule

// File: tb/tb_coin_dispense_sequencer.sv
// Directed bench for coin_dispense_sequencer with behavioural servo models:
// a done flag drops 2 cycles after its ctrl edge and rises 50 cycles later.
module tb_coin_dispense_sequencer;

   localparam int unsigned AMT_W = 7;
   localparam int unsigned TMO   = 1000;

   logic             clk = 1'b0;
   logic             clr;
   logic             req_valid;
   logic [AMT_W-1:0] req_cents;
   logic             req_ready;
   logic [3:0]       servo_ctrl;
   logic [3:0]       servo_back_done;
   logic [3:0]       servo_front_done;
   logic             busy;
   logic             done;
   logic             fault;
   logic [AMT_W-1:0] dispensed_cents;
`ifdef COIN_TALLY_EN
   logic [31:0]      tally;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   coin_dispense_sequencer #(
      .TIMEOUT_CYCLES (TMO),
      .AMT_W          (AMT_W)
   ) dut (
      .clk              (clk),
      .clr              (clr),
      .req_valid        (req_valid),
      .req_cents        (req_cents),
      .req_ready        (req_ready),
      .servo_ctrl       (servo_ctrl),
      .servo_back_done  (servo_back_done),
      .servo_front_done (servo_front_done),
      .busy             (busy),
      .done             (done),
      .fault            (fault),
`ifdef COIN_TALLY_EN
      .tally            (tally),
`endif
      .dispensed_cents  (dispensed_cents)
   );

   // Servo models
   logic       stuck_q = 1'b0;
   logic [3:0] model_prev;
   int         bcnt[4];
   int         fcnt[4];

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (clr) begin
            servo_back_done[i]  <= 1'b1;
            servo_front_done[i] <= 1'b1;
            bcnt[i]             <= 0;
            fcnt[i]             <= 0;
         end else begin
            if (servo_ctrl[i] && !model_prev[i]) begin
               bcnt[i] <= 1;
            end else if (bcnt[i] != 0) begin
               if (bcnt[i] == 1 && !(stuck_q && i == 3)) servo_back_done[i] <= 1'b0;
               if (bcnt[i] == 51) begin
                  servo_back_done[i] <= 1'b1;
                  bcnt[i]            <= 0;
               end else begin
                  bcnt[i] <= bcnt[i] + 1;
               end
            end
            if (!servo_ctrl[i] && model_prev[i]) begin
               fcnt[i] <= 1;
            end else if (fcnt[i] != 0) begin
               if (fcnt[i] == 1) servo_front_done[i] <= 1'b0;
               if (fcnt[i] == 51) begin
                  servo_front_done[i] <= 1'b1;
                  fcnt[i]             <= 0;
               end else begin
                  fcnt[i] <= fcnt[i] + 1;
               end
            end
         end
      end
      model_prev <= clr ? 4'b0000 : servo_ctrl;
   end

   // Activity monitor: stroke order, one-hot violations, done pulses
   int         strokes[$];
   logic       multi_hot;
   int         done_cnt;
   logic [3:0] mon_prev = 4'b0000;

   always @(posedge clk) begin
      if (!clr) begin
         for (int i = 0; i < 4; i++) begin
            if (servo_ctrl[i] && !mon_prev[i]) strokes.push_back(i);
         end
         if ($countones(servo_ctrl) > 1) multi_hot = 1'b1;
         if (done) done_cnt++;
      end
      mon_prev = servo_ctrl;
   end

   task automatic clear_monitor();
      strokes.delete();
      multi_hot = 1'b0;
      done_cnt  = 0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_req(input int cents);
      req_cents = AMT_W'(cents);
      req_valid = 1'b1;
      tick(1);
      req_valid = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         tick(1);
         if (done) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset();
      clr       = 1'b1;
      req_valid = 1'b0;
      req_cents = '0;
      tick(2);
      n_cmp++;
      if ({servo_ctrl, req_ready, busy, done, fault, dispensed_cents} !==
          {4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0}) begin
         n_err++;
         $display("FAIL reset_outputs: got ctrl=%b rdy=%b busy=%b done=%b fault=%b disp=%0d, want 0 1 0 0 0 0",
                  servo_ctrl, req_ready, busy, done, fault, dispensed_cents);
      end
      clr = 1'b0;
      tick(1);
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ready_after_release: got %b want 1", req_ready);
      end
   endtask

   task automatic test_dispense_41();
      bit ok;
      int exp_s[$] = '{3, 2, 1, 0};
      clear_monitor();
      start_req(41);
      n_cmp++;
      if ({busy, req_ready} !== 2'b10) begin
         n_err++;
         $display("FAIL d41_busy_after_accept: got busy=%b rdy=%b want 1 0", busy, req_ready);
      end
      wait_done(ok);
      n_cmp++;
      if (!ok) begin
         n_err++;
         $display("FAIL d41_done_seen: got no done want done");
      end
      n_cmp++;
      if (dispensed_cents !== 7'd41) begin
         n_err++;
         $display("FAIL d41_dispensed: got %0d want 41", dispensed_cents);
      end
      tick(3);
      n_cmp++;
      if (strokes != exp_s) begin
         n_err++;
         $display("FAIL d41_stroke_order: got %p want %p", strokes, exp_s);
      end
      n_cmp++;
      if (multi_hot !== 1'b0) begin
         n_err++;
         $display("FAIL d41_one_hot: got multi-hot=%b want 0", multi_hot);
      end
      n_cmp++;
      if (done_cnt != 1) begin
         n_err++;
         $display("FAIL d41_done_pulses: got %0d want 1", done_cnt);
      end
      n_cmp++;
      if ({busy, req_ready, servo_ctrl, dispensed_cents} !== {1'b0, 1'b1, 4'b0000, 7'd41}) begin
         n_err++;
         $display("FAIL d41_idle_after: got busy=%b rdy=%b ctrl=%b disp=%0d want 0 1 0000 41",
                  busy, req_ready, servo_ctrl, dispensed_cents);
      end
   endtask

   task automatic test_dispense_99();
      bit ok;
      int exp_s[$] = '{3, 3, 3, 2, 2, 0, 0, 0, 0};
      clear_monitor();
      start_req(99);
      wait_done(ok);
      n_cmp++;
      if (!ok || dispensed_cents !== 7'd99) begin
         n_err++;
         $display("FAIL d99_done_total: got done=%b disp=%0d want 1 99", ok, dispensed_cents);
      end
      tick(3);
      n_cmp++;
      if (strokes != exp_s) begin
         n_err++;
         $display("FAIL d99_stroke_order: got %p want %p", strokes, exp_s);
      end
      n_cmp++;
      if (multi_hot !== 1'b0 || done_cnt != 1) begin
         n_err++;
         $display("FAIL d99_onehot_done: got multi=%b done_cnt=%0d want 0 1", multi_hot, done_cnt);
      end
   endtask

   task automatic test_zero();
      clear_monitor();
      start_req(0);
      n_cmp++;
      if ({busy, done, req_ready} !== 3'b100) begin
         n_err++;
         $display("FAIL zero_cycle1: got busy=%b done=%b rdy=%b want 1 0 0", busy, done, req_ready);
      end
      tick(1);
      n_cmp++;
      if ({busy, done, req_ready, servo_ctrl} !== {3'b010, 4'b0000}) begin
         n_err++;
         $display("FAIL zero_cycle2_done: got busy=%b done=%b rdy=%b ctrl=%b want 0 1 0 0000",
                  busy, done, req_ready, servo_ctrl);
      end
      tick(1);
      n_cmp++;
      if ({done, req_ready, dispensed_cents} !== {2'b01, 7'd0}) begin
         n_err++;
         $display("FAIL zero_cycle3_idle: got done=%b rdy=%b disp=%0d want 0 1 0",
                  done, req_ready, dispensed_cents);
      end
      tick(2);
      n_cmp++;
      if (strokes.size() != 0 || done_cnt != 1) begin
         n_err++;
         $display("FAIL zero_no_servo: got strokes=%0d done_cnt=%0d want 0 1",
                  strokes.size(), done_cnt);
      end
   endtask

   task automatic test_ignore_busy_req();
      bit ok;
      int exp_s[$] = '{3, 2, 1, 0};
      clear_monitor();
      start_req(41);
      tick(60);
      n_cmp++;
      if (req_ready !== 1'b0) begin
         n_err++;
         $display("FAIL ign_ready_low_busy: got %b want 0", req_ready);
      end
      req_cents = 7'd99;
      req_valid = 1'b1;
      tick(3);
      req_valid = 1'b0;
      wait_done(ok);
      tick(3);
      n_cmp++;
      if (!ok || dispensed_cents !== 7'd41) begin
         n_err++;
         $display("FAIL ign_total: got done=%b disp=%0d want 1 41", ok, dispensed_cents);
      end
      n_cmp++;
      if (strokes != exp_s || done_cnt != 1) begin
         n_err++;
         $display("FAIL ign_strokes: got %p done_cnt=%0d want %p 1", strokes, done_cnt, exp_s);
      end
   endtask

   task automatic test_timeout();
      clear_monitor();
      stuck_q = 1'b1;
      start_req(30);
      tick(1);
      n_cmp++;
      if (servo_ctrl !== 4'b1000) begin
         n_err++;
         $display("FAIL tmo_push_start: got ctrl=%b want 1000", servo_ctrl);
      end
      tick(int'(TMO) - 1);
      n_cmp++;
      if ({fault, servo_ctrl, busy} !== {1'b0, 4'b1000, 1'b1}) begin
         n_err++;
         $display("FAIL tmo_before_limit: got fault=%b ctrl=%b busy=%b want 0 1000 1",
                  fault, servo_ctrl, busy);
      end
      tick(1);
      n_cmp++;
      if ({fault, servo_ctrl, busy, req_ready, dispensed_cents} !==
          {1'b1, 4'b0000, 1'b0, 1'b0, 7'd0}) begin
         n_err++;
         $display("FAIL tmo_at_limit: got fault=%b ctrl=%b busy=%b rdy=%b disp=%0d want 1 0000 0 0 0",
                  fault, servo_ctrl, busy, req_ready, dispensed_cents);
      end
      req_cents = 7'd5;
      req_valid = 1'b1;
      tick(5);
      req_valid = 1'b0;
      n_cmp++;
      if ({fault, req_ready, busy, servo_ctrl} !== {3'b100, 4'b0000}) begin
         n_err++;
         $display("FAIL tmo_sticky: got fault=%b rdy=%b busy=%b ctrl=%b want 1 0 0 0000",
                  fault, req_ready, busy, servo_ctrl);
      end
      stuck_q = 1'b0;
      clr     = 1'b1;
      tick(1);
      clr = 1'b0;
      n_cmp++;
      if ({fault, req_ready} !== 2'b01) begin
         n_err++;
         $display("FAIL tmo_cleared_by_clr: got fault=%b rdy=%b want 0 1", fault, req_ready);
      end
   endtask

   task automatic test_clr_mid_stroke();
      bit ok;
      int exp_s[$] = '{1};
      clear_monitor();
      start_req(5);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (!servo_back_done[1]) begin
            ok = 1'b1;
            break;
         end
      end
      tick(5);
      n_cmp++;
      if (!ok || servo_ctrl !== 4'b0010) begin
         n_err++;
         $display("FAIL clr_reach_push_wait: got ack=%b ctrl=%b want 1 0010", ok, servo_ctrl);
      end
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      n_cmp++;
      if ({servo_ctrl, req_ready, busy, done, fault, dispensed_cents} !==
          {4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0}) begin
         n_err++;
         $display("FAIL clr_mid_outputs: got ctrl=%b rdy=%b busy=%b done=%b fault=%b disp=%0d want 0000 1 0 0 0 0",
                  servo_ctrl, req_ready, busy, done, fault, dispensed_cents);
      end
      clear_monitor();
      start_req(5);
      wait_done(ok);
      tick(2);
      n_cmp++;
      if (!ok || dispensed_cents !== 7'd5 || strokes != exp_s) begin
         n_err++;
         $display("FAIL clr_then_req5: got done=%b disp=%0d strokes=%p want 1 5 %p",
                  ok, dispensed_cents, strokes, exp_s);
      end
   endtask

   initial begin
      clr       = 1'b1;
      req_valid = 1'b0;
      req_cents = '0;
      clear_monitor();
      test_reset();
      test_dispense_41();
      test_dispense_99();
      test_zero();
      test_ignore_busy_req();
      test_timeout();
      test_clr_mid_stroke();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
